// File: rtl/stream_mux_pkg.sv
// Shared encodings and helpers for the stream_mux_rr block.
package stream_mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  function automatic int unsigned wrap_inc(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter with optional grant hold.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int CW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [CW-1:0] ptr_i,
  input  logic          hold_i,
  input  logic [CW-1:0] hold_idx_i,
  output logic [N-1:0]  gnt_o,
  output logic [CW-1:0] gnt_idx_o
);

  logic found;
  int   idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    if (hold_i) begin
      for (int i = 0; i < N; i++) begin
        if (hold_idx_i == CW'(i) && req_i[i]) begin
          gnt_o[i]  = 1'b1;
          gnt_idx_o = CW'(i);
        end
      end
    end else begin
      // Scan from ptr upward, wrapping modulo N.
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr_i) + k;
        if (idx >= N) idx = idx - N;
        for (int i = 0; i < N; i++) begin
          if (!found && i == idx && req_i[i]) begin
            found     = 1'b1;
            gnt_o[i]  = 1'b1;
            gnt_idx_o = CW'(i);
          end
        end
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel stream mux, round-robin or fixed select, registered output.
// Optional packet lock: define MUX_PKT_LOCK_EN.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [CW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [CW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] out_ch_q, out_ch_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;

  logic [N-1:0]  arb_gnt;
  logic [CW-1:0] arb_idx, fix_idx, g;
  logic          fix_any, grant_any, load, hold;
  logic [W-1:0]  g_data;
  logic          g_last;

  rr_arbiter #(.N(N), .CW(CW)) u_arb (
    .req_i      (in_valid),
    .ptr_i      (ptr_q),
    .hold_i     (hold),
    .hold_idx_i (out_ch_q),
    .gnt_o      (arb_gnt),
    .gnt_idx_o  (arb_idx)
  );

  always_comb begin
    fix_any = 1'b0;
    fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == CW'(i) && in_valid[i]) begin
        fix_any = 1'b1;
        fix_idx = CW'(i);
      end
    end
  end

  always_comb begin
    if (mode == MODE_FIXED) begin
      grant_any = fix_any;
      g         = fix_idx;
    end else begin
      grant_any = |arb_gnt;
      g         = arb_idx;
    end
  end

  assign load = rst_n && grant_any && (!out_valid_q || out_ready);

  always_comb begin
    in_ready = '0;
    g_data   = '0;
    g_last   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (g == CW'(i)) begin
        in_ready[i] = load;
        g_data      = in_data[i*W +: W];
        g_last      = in_last[i];
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_ch_d    = g;
      out_data_d  = g_data;
      out_valid_d = 1'b1;
      if (mode == MODE_RR) ptr_d = CW'(wrap_inc(32'(g), N));
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef MUX_PKT_LOCK_EN
  logic lock_q, lock_d;

  // The locked channel is always the one last loaded, i.e. out_ch_q.
  assign hold = lock_q && (mode == MODE_RR);

  always_comb begin
    lock_d = lock_q;
    if (mode == MODE_FIXED) lock_d = 1'b0;
    else if (load)          lock_d = !g_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= 1'b0;
    else        lock_q <= lock_d;
  end
`else
  logic unused_last;
  assign hold        = 1'b0;
  assign unused_last = ^in_last ^ g_last;
`endif

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed-vector bench for stream_mux_rr (N=4 main, N=5 for sel >= N).
module tb_stream_mux_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_last, in_ready;
  logic        mode, out_ready, out_valid;
  logic [1:0]  sel, out_ch;
  logic [7:0]  out_data;

  logic [39:0] d5;
  logic [4:0]  v5, ir5;
  logic [2:0]  sel5, ch5;
  logic        ov5;
  logic [7:0]  od5;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N(4), .W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready),
    .mode(mode), .sel(sel),
    .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_mux_rr #(.N(5), .W(8)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .in_data(d5), .in_valid(v5),
    .in_last(5'b0), .in_ready(ir5),
    .mode(1'b1), .sel(sel5),
    .out_data(od5), .out_ch(ch5),
    .out_valid(ov5), .out_ready(1'b1)
  );

  typedef struct {
    logic [3:0] v;
    logic       m;
    logic [1:0] s;
    logic       rdy;
    logic [3:0] ir;
    logic       ov;
    logic [1:0] ch;
    logic [7:0] d;
  } vec_t;

  vec_t tv[22];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  initial begin
    logic [3:0] lv[5], ll[5], lir[5];
    logic [1:0] lch[5];
    logic       lov[5];

    tv[0]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0};
    tv[1]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'h2, 1'b1, 2'd1, 8'hA1};
    tv[2]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA2};
    tv[3]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'h8, 1'b1, 2'd3, 8'hA3};
    tv[4]  = '{4'hF, 1'b0, 2'd0, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0};
    tv[5]  = '{4'h2, 1'b0, 2'd0, 1'b1, 4'h2, 1'b1, 2'd1, 8'hA1};
    tv[6]  = '{4'hA, 1'b0, 2'd0, 1'b1, 4'h8, 1'b1, 2'd3, 8'hA3};
    tv[7]  = '{4'hA, 1'b0, 2'd0, 1'b1, 4'h2, 1'b1, 2'd1, 8'hA1};
    tv[8]  = '{4'hA, 1'b0, 2'd0, 1'b1, 4'h8, 1'b1, 2'd3, 8'hA3};
    for (int i = 9; i < 14; i++)
      tv[i] = '{4'hF, 1'b0, 2'd0, 1'b0, 4'h0, 1'b1, 2'd3, 8'hA3};
    tv[14] = '{4'hF, 1'b0, 2'd0, 1'b1, 4'h1, 1'b1, 2'd0, 8'hA0};
    tv[15] = '{4'hF, 1'b1, 2'd2, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA2};
    tv[16] = '{4'hF, 1'b1, 2'd2, 1'b1, 4'h4, 1'b1, 2'd2, 8'hA2};
    tv[17] = '{4'hB, 1'b1, 2'd2, 1'b1, 4'h0, 1'b0, 2'd2, 8'hA2};
    tv[18] = '{4'h0, 1'b0, 2'd0, 1'b1, 4'h0, 1'b0, 2'd2, 8'hA2};
    tv[19] = '{4'hF, 1'b0, 2'd0, 1'b1, 4'h2, 1'b1, 2'd1, 8'hA1};
    tv[20] = '{4'h0, 1'b0, 2'd0, 1'b0, 4'h0, 1'b1, 2'd1, 8'hA1};
    tv[21] = '{4'h0, 1'b0, 2'd0, 1'b1, 4'h0, 1'b0, 2'd1, 8'hA1};

    lv  = '{4'h6, 4'h4, 4'h6, 4'h6, 4'h4};
    ll  = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h0};
`ifdef MUX_PKT_LOCK_EN
    lir = '{4'h2, 4'h0, 4'h2, 4'h2, 4'h4};
    lch = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    lov = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`else
    lir = '{4'h2, 4'h4, 4'h2, 4'h4, 4'h4};
    lch = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd2};
    lov = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif

    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    d5        = {8'hB4, 8'hB3, 8'hB2, 8'hB1, 8'hB0};
    in_valid  = 4'hF;
    in_last   = 4'h0;
    mode      = 1'b0;
    sel       = 2'd0;
    out_ready = 1'b1;
    v5        = 5'h0;
    sel5      = 3'd0;
    rst_n     = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      in_valid  = tv[i].v;
      mode      = tv[i].m;
      sel       = tv[i].s;
      out_ready = tv[i].rdy;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, tv[i].ir);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), out_valid, tv[i].ov);
      chk($sformatf("v%0d_out_ch", i), out_ch, tv[i].ch);
      chk($sformatf("v%0d_out_data", i), out_data, tv[i].d);
    end

    // Asynchronous reset with a beat held in the output stage.
    in_valid  = 4'hF;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_out_valid_held", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_in_ready", in_ready, 0);
    in_valid = 4'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_in_ready_idle", in_ready, 0);
    chk("post_out_ch", out_ch, 0);
    chk("post_out_data", out_data, 0);
    in_valid  = 4'hF;
    out_ready = 1'b1;
    #1;
    chk("post_ptr0_grant", in_ready, 4'h1);
    @(posedge clk);
    #1;
    chk("post_out_ch0", out_ch, 0);

    // Packet lock sequence from a fresh pointer.
    rst_n = 1'b0;
    in_valid = 4'h0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = lv[i];
      in_last  = ll[i];
      #1;
      chk($sformatf("lock%0d_in_ready", i), in_ready, lir[i]);
      @(posedge clk);
      #1;
      chk($sformatf("lock%0d_out_ch", i), out_ch, lch[i]);
      chk($sformatf("lock%0d_out_valid", i), out_valid, lov[i]);
    end
    in_valid = 4'h0;
    in_last  = 4'h0;

    // Fixed select out of range on a 5-channel instance.
    v5   = 5'h1F;
    sel5 = 3'd5;
    #1;
    chk("n5_sel5_in_ready", ir5, 0);
    @(posedge clk);
    #1;
    chk("n5_sel5_out_valid", ov5, 0);
    sel5 = 3'd4;
    #1;
    chk("n5_sel4_in_ready", ir5, 5'h10);
    @(posedge clk);
    #1;
    chk("n5_sel4_out_valid", ov5, 1);
    chk("n5_sel4_out_ch", ch5, 4);
    chk("n5_sel4_out_data", od5, 8'hB4);
    sel5 = 3'd5;
    #1;
    chk("n5_back5_in_ready", ir5, 0);
    @(posedge clk);
    #1;
    chk("n5_drain_out_valid", ov5, 0);
    chk("n5_drain_out_ch", ch5, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
